// File: rtl/tpu_ctrl_pkg.sv
// Shared definitions for the TPU tile sequencer: FSM state encoding,
// default sizing and the systolic drain-length helper.
package tpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_COMP   = 3'd2,
    S_DRAIN  = 3'd3,
    S_WRITE  = 3'd4,
    S_FINISH = 3'd5,
    S_ERR    = 3'd6
  } seq_state_t;

  localparam int DEFAULT_ARRAY_SIZE = 8;
  localparam int DEFAULT_TILE_W     = 8;
  localparam int DEFAULT_TIMEOUT    = 1024;

  // Cycles for the last partial sums to ripple out of an NxN array.
  function automatic int drain_cyc(input int array_size);
    return 2 * array_size - 2;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seq_phase_timer.sv
// Loadable down-counter used for the drain interval and the phase watchdog.
// Load has priority; otherwise it decrements while enabled and rests at zero.
module seq_phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  // Counter register: reload, or count down towards zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (en && (count_reg != '0)) begin
      count_reg <= count_reg - W'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/systolic_tile_sequencer.sv
// Multi-tile READ -> COMPUTE -> DRAIN -> WRITE sequencer for the systolic array.
// Launch pulses are gated on FIFO status; done inputs are only honoured in
// their own phase after the launch pulse has gone out.
// Optional build macro SEQ_WATCHDOG_EN: adds a per-phase wait watchdog that
// drives the FSM into ERR and raises the sticky error output.
module systolic_tile_sequencer
  import tpu_ctrl_pkg::*;
#(
  parameter int ARRAY_SIZE = DEFAULT_ARRAY_SIZE,
  parameter int TILE_W     = DEFAULT_TILE_W,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [TILE_W-1:0] num_tiles,
  input  logic              rempty,
  input  logic              wfull,
  input  logic              read_done,
  input  logic              compute_done,
  input  logic              write_done,
  output logic              read_start,
  output logic              compute_start,
  output logic              write_start,
  output logic              busy,
  output logic [TILE_W-1:0] tile_idx,
  output logic              done,
  output logic              aborted,
  output logic              error,
  output logic [2:0]        state
);

  localparam int DRAIN_CYC = drain_cyc(ARRAY_SIZE);
  // One timer width covers both the drain count and the watchdog limit.
  localparam int TMR_W = $clog2(max_int(max_int(DRAIN_CYC, TIMEOUT), 1) + 1);
  localparam logic [TMR_W-1:0] DRAIN_LOAD = TMR_W'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);

  seq_state_t        state_reg, state_next;
  logic [TILE_W-1:0] tile_idx_reg, tile_idx_next;
  logic [TILE_W-1:0] count_reg, count_next;
  logic              launched_reg, launched_next;
  logic              read_start_reg, read_start_next;
  logic              compute_start_reg, compute_start_next;
  logic              write_start_reg, write_start_next;
  logic              done_reg, done_next;
  logic              aborted_reg, aborted_next;
  logic              error_reg, error_next;
  logic              armed;
  logic              wd_fire;
  logic [TMR_W-1:0]  drain_cnt;

  // A done input counts only once the phase's launch pulse has been seen.
  assign armed = launched_reg & ~(read_start_reg | compute_start_reg | write_start_reg);

  seq_phase_timer #(.W(TMR_W)) u_drain_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (state_reg != S_DRAIN),
    .en       (state_reg == S_DRAIN),
    .load_val (DRAIN_LOAD),
    .count    (drain_cnt)
  );

`ifdef SEQ_WATCHDOG_EN
  logic             wait_phase;
  logic [TMR_W-1:0] wd_cnt;

  assign wait_phase = (state_reg == S_READ) || (state_reg == S_COMP) || (state_reg == S_WRITE);

  // Held at its limit until the phase is armed; any state change disarms it.
  seq_phase_timer #(.W(TMR_W)) u_wd_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (~(wait_phase & armed)),
    .en       (1'b1),
    .load_val (TMR_W'(TIMEOUT - 1)),
    .count    (wd_cnt)
  );

  assign wd_fire = wait_phase & armed & (wd_cnt == '0);
`else
  assign wd_fire = 1'b0;
`endif

  // State and registered-output update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg         <= S_IDLE;
      tile_idx_reg      <= '0;
      count_reg         <= '0;
      launched_reg      <= 1'b0;
      read_start_reg    <= 1'b0;
      compute_start_reg <= 1'b0;
      write_start_reg   <= 1'b0;
      done_reg          <= 1'b0;
      aborted_reg       <= 1'b0;
      error_reg         <= 1'b0;
    end else begin
      state_reg         <= state_next;
      tile_idx_reg      <= tile_idx_next;
      count_reg         <= count_next;
      launched_reg      <= launched_next;
      read_start_reg    <= read_start_next;
      compute_start_reg <= compute_start_next;
      write_start_reg   <= write_start_next;
      done_reg          <= done_next;
      aborted_reg       <= aborted_next;
      error_reg         <= error_next;
    end
  end

  // Next-state and pulse decisions; abort outranks every transition.
  always_comb begin
    state_next         = state_reg;
    tile_idx_next      = tile_idx_reg;
    count_next         = count_reg;
    launched_next      = launched_reg;
    read_start_next    = 1'b0;
    compute_start_next = 1'b0;
    write_start_next   = 1'b0;
    done_next          = 1'b0;
    aborted_next       = 1'b0;
    error_next         = error_reg;

    if (abort && (state_reg != S_IDLE)) begin
      state_next    = S_IDLE;
      aborted_next  = 1'b1;
      launched_next = 1'b0;
    end else begin
      case (state_reg)
        S_IDLE, S_ERR: begin
          if (start) begin
            count_next    = num_tiles;
            tile_idx_next = '0;
            launched_next = 1'b0;
            error_next    = 1'b0;
            state_next    = (num_tiles == '0) ? S_FINISH : S_READ;
          end
        end
        S_READ: begin
          if (!launched_reg) begin
            if (!rempty) begin
              read_start_next = 1'b1;
              launched_next   = 1'b1;
            end
          end else if (armed && read_done) begin
            state_next    = S_COMP;
            launched_next = 1'b0;
          end else if (wd_fire) begin
            state_next    = S_ERR;
            launched_next = 1'b0;
            error_next    = 1'b1;
          end
        end
        S_COMP: begin
          if (!launched_reg) begin
            compute_start_next = 1'b1;
            launched_next      = 1'b1;
          end else if (armed && compute_done) begin
            state_next    = (DRAIN_CYC == 0) ? S_WRITE : S_DRAIN;
            launched_next = 1'b0;
          end else if (wd_fire) begin
            state_next    = S_ERR;
            launched_next = 1'b0;
            error_next    = 1'b1;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == '0) begin
            state_next = S_WRITE;
          end
        end
        S_WRITE: begin
          if (!launched_reg) begin
            if (!wfull) begin
              write_start_next = 1'b1;
              launched_next    = 1'b1;
            end
          end else if (armed && write_done) begin
            launched_next = 1'b0;
            if (tile_idx_reg == count_reg - TILE_W'(1)) begin
              state_next = S_FINISH;
            end else begin
              tile_idx_next = tile_idx_reg + TILE_W'(1);
              state_next    = S_READ;
            end
          end else if (wd_fire) begin
            state_next    = S_ERR;
            launched_next = 1'b0;
            error_next    = 1'b1;
          end
        end
        S_FINISH: begin
          done_next  = 1'b1;
          state_next = S_IDLE;
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase
    end
  end

  assign read_start    = read_start_reg;
  assign compute_start = compute_start_reg;
  assign write_start   = write_start_reg;
  assign done          = done_reg;
  assign aborted       = aborted_reg;
  assign error         = error_reg;
  assign tile_idx      = tile_idx_reg;
  assign busy          = (state_reg != S_IDLE);
  assign state         = state_reg;

endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// Scoreboard bench for systolic_tile_sequencer: every launch/done/aborted
// pulse is matched, in order, against events queued when a job is started.
module tb_systolic_tile_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, abort, rempty, wfull;
  logic [7:0] num_tiles;
  logic       read_done, compute_done, write_done;
  logic       read_start, compute_start, write_start, busy, done, aborted, error;
  logic [7:0] tile_idx;
  logic [2:0] state;

  // Done inputs: auto responder OR manual drive from the main sequence.
  logic a_rd = 1'b0, a_cd = 1'b0, a_wd = 1'b0;
  logic m_rd = 1'b0, m_cd = 1'b0, m_wd = 1'b0;
  assign read_done    = a_rd | m_rd;
  assign compute_done = a_cd | m_cd;
  assign write_done   = a_wd | m_wd;

  always #5 clk = ~clk;

  systolic_tile_sequencer #(.ARRAY_SIZE(8), .TILE_W(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .num_tiles(num_tiles),
    .rempty(rempty), .wfull(wfull), .read_done(read_done),
    .compute_done(compute_done), .write_done(write_done),
    .read_start(read_start), .compute_start(compute_start),
    .write_start(write_start), .busy(busy), .tile_idx(tile_idx),
    .done(done), .aborted(aborted), .error(error), .state(state)
  );

  int errors = 0;
  int checks = 0;
  int unsigned exp_q[$];
  int rs_cnt = 0, cs_cnt = 0, ws_cnt = 0, done_cnt = 0, ab_cnt = 0;
  int drain_run = 0;
  logic [2:0] prev_state = 3'd0;
  bit auto_en = 1'b0;
  bit hold_wd = 1'b0;
  int rt = 0, ct = 0, wt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Event codes: 0 read_start, 1 compute_start, 2 write_start, 3 done, 4 aborted.
  task automatic push_job(input int n);
    for (int t = 0; t < n; t++) begin
      exp_q.push_back(0 * 1000 + t);
      exp_q.push_back(1 * 1000 + t);
      exp_q.push_back(2 * 1000 + t);
    end
    exp_q.push_back(3 * 1000 + ((n == 0) ? 0 : n - 1));
  endtask

  task automatic sb(input int code);
    int unsigned obs;
    obs = code * 1000 + tile_idx;
    $display("event code=%0d tile=%0d t=%0t", code, tile_idx, $time);
    if (exp_q.size() == 0) check("sb_extra", obs, 99999);
    else check("sb_evt", obs, exp_q.pop_front());
  endtask

  // Auto responder: each done arrives 5 cycles after its launch pulse.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      a_rd = 1'b0; a_cd = 1'b0; a_wd = 1'b0;
      if (!auto_en || rst) begin
        rt = 0; ct = 0; wt = 0;
      end else begin
        if (rt > 0) begin rt--; if (rt == 0) a_rd = 1'b1; end
        if (ct > 0) begin ct--; if (ct == 0) a_cd = 1'b1; end
        if (wt > 0) begin wt--; if (wt == 0 && !hold_wd) a_wd = 1'b1; end
        if (read_start)    rt = 5;
        if (compute_start) ct = 5;
        if (write_start)   wt = 5;
      end
    end
  end

  // Output monitor: scoreboard pops and drain-length measurement.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (read_start)    begin rs_cnt++;   sb(0); end
        if (compute_start) begin cs_cnt++;   sb(1); end
        if (write_start)   begin ws_cnt++;   sb(2); end
        if (done)          begin done_cnt++; sb(3); end
        if (aborted)       begin ab_cnt++;   sb(4); end
        if (state == 3'd3) begin
          drain_run++;
        end else begin
          if (prev_state == 3'd3 && state == 3'd4) check("drain_len", drain_run, 14);
          drain_run = 0;
        end
        prev_state = state;
      end
    end
  end

  task automatic drive_start(input int n);
    start = 1'b1;
    num_tiles = 8'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int bound, input string tag);
    int i = 0;
    while (state !== s && i < bound) begin @(negedge clk); i++; end
    if (state !== s) check(tag, state, s);
  endtask

  task automatic wait_done(input int prev, input int bound, input string tag);
    int i = 0;
    while (done_cnt == prev && i < bound) begin @(negedge clk); i++; end
    check(tag, done_cnt, prev + 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int prev, r0, w0, i;
    rst = 1'b1; start = 1'b0; abort = 1'b0; rempty = 1'b0; wfull = 1'b0; num_tiles = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_state", state, 0);
    check("rst_busy", busy, 0);
    check("rst_tile", tile_idx, 0);
    check("rst_pulses", {read_start, compute_start, write_start, done, aborted}, 0);
    check("rst_error", error, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Three-tile job with automatic done responses.
    auto_en = 1'b1;
    push_job(3);
    prev = done_cnt; r0 = rs_cnt;
    drive_start(3);
    wait_done(prev, 600, "t1_done");
    check("t1_reads", rs_cnt - r0, 3);
    check("t1_writes", ws_cnt, 3);
    check("t1_computes", cs_cnt, 3);
    check("t1_tile", tile_idx, 2);
    @(negedge clk);
    check("t1_idle", busy, 0);

    // Zero-tile job: FINISH for one cycle, done two cycles after start.
    @(posedge clk); #1;
    r0 = rs_cnt;
    exp_q.push_back(3000);
    start = 1'b1; num_tiles = 8'd0;
    @(negedge clk);
    check("t2_busy_c0", busy, 0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("t2_busy_c1", busy, 1);
    check("t2_state_c1", state, 5);
    check("t2_done_c1", done, 0);
    @(negedge clk);
    check("t2_done_c2", done, 1);
    check("t2_busy_c2", busy, 0);
    check("t2_no_reads", rs_cnt - r0, 0);

    // FIFO gating of read_start and write_start.
    @(posedge clk); #1;
    rempty = 1'b1; wfull = 1'b1;
    push_job(1);
    prev = done_cnt; r0 = rs_cnt; w0 = ws_cnt;
    drive_start(1);
    repeat (10) @(negedge clk);
    check("t3_read_held", state, 1);
    check("t3_no_rs", rs_cnt - r0, 0);
    @(posedge clk); #1;
    rempty = 1'b0;
    @(negedge clk);
    check("t3_rs_early", read_start, 0);
    @(negedge clk);
    check("t3_rs_pulse", read_start, 1);
    wait_state(3'd4, 300, "t3_reach_write");
    repeat (10) @(negedge clk);
    check("t3_no_ws", ws_cnt - w0, 0);
    @(posedge clk); #1;
    wfull = 1'b0;
    @(negedge clk);
    check("t3_ws_early", write_start, 0);
    @(negedge clk);
    check("t3_ws_pulse", write_start, 1);
    wait_done(prev, 300, "t3_done");

    // Abort during the DRAIN of tile 1, then a clean two-tile restart.
    @(posedge clk); #1;
    push_job(3);
    prev = done_cnt;
    drive_start(3);
    i = 0;
    while (!(state == 3'd3 && tile_idx == 8'd1) && i < 400) begin @(negedge clk); i++; end
    check("t4_reach_drain1", {state, tile_idx}, {3'd3, 8'd1});
    exp_q.delete();
    exp_q.push_back(4001);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("t4_state", state, 0);
    check("t4_aborted", aborted, 1);
    check("t4_tile", tile_idx, 1);
    repeat (20) @(negedge clk);
    check("t4_no_done", done_cnt, prev);
    @(posedge clk); #1;
    push_job(2);
    prev = done_cnt;
    drive_start(2);
    wait_done(prev, 400, "t4_restart_done");
    check("t4_restart_tile", tile_idx, 1);

    // Spurious compute_done in READ, read_done on the read_start cycle.
    @(posedge clk); #1;
    auto_en = 1'b0;
    rempty = 1'b1;
    exp_q.push_back(0);
    exp_q.push_back(4000);
    drive_start(1);
    m_cd = 1'b1;
    @(posedge clk); #1;
    m_cd = 1'b0;
    @(negedge clk);
    check("t5_spur_cd", state, 1);
    @(posedge clk); #1;
    rempty = 1'b0;
    @(posedge clk); #1;
    m_rd = 1'b1;
    @(negedge clk);
    check("t5_rs_now", read_start, 1);
    @(posedge clk); #1;
    m_rd = 1'b0;
    @(negedge clk);
    check("t5_rd_ignored", state, 1);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("t5_abort_idle", state, 0);

`ifdef SEQ_WATCHDOG_EN
    // Withheld write_done: ERR exactly TIMEOUT armed cycles after write_start.
    @(posedge clk); #1;
    auto_en = 1'b1; hold_wd = 1'b1;
    exp_q.push_back(0); exp_q.push_back(1000); exp_q.push_back(2000);
    drive_start(1);
    i = 0;
    while (write_start !== 1'b1 && i < 300) begin @(negedge clk); i++; end
    check("t6_ws_seen", write_start, 1);
    repeat (16) @(negedge clk);
    check("t6_still_write", state, 4);
    @(negedge clk);
    check("t6_err_state", state, 6);
    check("t6_error", error, 1);
    @(posedge clk); #1;
    hold_wd = 1'b0;
    push_job(1);
    prev = done_cnt;
    drive_start(1);
    @(negedge clk);
    check("t6_error_clr", error, 0);
    check("t6_new_read", state, 1);
    wait_done(prev, 300, "t6_done");
`else
    check("t6_error_tied", error, 0);
`endif

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/systolic_tile_sequencer.md
Name: systolic_tile_sequencer

Overview:
Multi-tile successor to the single-pass TPU read/compute/write controller. Sequences a programmable number of tiles through the READ -> COMPUTE -> DRAIN -> WRITE phases. Gates phase launch on FIFO status and inserts a parametrised systolic drain interval. Sits between the host start/done interface and the loader, systolic array and writeback engines.

Parameters:
ARRAY_SIZE, 8, systolic array dimension; drain length DRAIN_CYC = 2*ARRAY_SIZE-2 cycles.
TILE_W, 8, width of tile count and tile index.
TIMEOUT, 1024, max cycles waiting for any *_done before error (used only with watchdog).

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
start  in  1  begin job; sampled only in IDLE
abort  in  1  cancel job; any state
num_tiles  in  TILE_W  tiles in job; latched when start is accepted
rempty  in  1  input FIFO empty
wfull  in  1  output FIFO full
read_done  in  1  loader finished current tile
compute_done  in  1  array finished last MAC of current tile
write_done  in  1  writeback finished current tile
read_start  out  1  one-cycle launch pulse to loader
compute_start  out  1  one-cycle launch pulse to array
write_start  out  1  one-cycle launch pulse to writeback
busy  out  1  high in any state except IDLE
tile_idx  out  TILE_W  index of current tile, 0-based
done  out  1  one-cycle pulse at job completion
aborted  out  1  one-cycle pulse when abort is taken
error  out  1  sticky watchdog error
state  out  3  encoded FSM state, for debug

Behaviour:
- Reset values: all outputs 0; state = IDLE; tile counter = 0; latched count = 0.
- States: IDLE=0, READ=1, COMP=2, DRAIN=3, WRITE=4, FINISH=5, ERR=6.
- IDLE:
  - start=1 latches num_tiles and clears tile_idx.
  - If num_tiles=0, go to FINISH; otherwise go to READ.
- Launch pulses (READ, COMP, WRITE): each phase issues exactly one *_start pulse per tile.
  - READ: pulse on the first cycle in state with rempty=0; held off while rempty=1.
  - COMP: pulse on the first cycle in state; no gating.
  - WRITE: pulse on the first cycle in state with wfull=0; held off while wfull=1.
- Done inputs:
  - Accepted only in the matching state, and only on cycles strictly after that phase's launch pulse.
  - Done inputs outside their phase, or on the launch-pulse cycle, are ignored.
- Transitions:
  - READ + read_done -> COMP.
  - COMP + compute_done -> DRAIN, or directly to WRITE if DRAIN_CYC=0.
  - DRAIN: down-counter loaded with DRAIN_CYC-1 on entry; moves to WRITE the cycle after it reaches 0, so DRAIN lasts exactly DRAIN_CYC cycles.
  - WRITE + write_done: if tile_idx = latched count - 1, go to FINISH; else increment tile_idx and go to READ.
- FINISH: done=1 for one cycle, then IDLE. tile_idx holds its last value until the next start.
- start while busy is ignored; the latched count does not change mid-job.
- abort:
  - Highest priority over every transition.
  - In any non-IDLE state: next cycle is IDLE, aborted pulses, no *_start or done issued that cycle, tile_idx frozen.
  - abort in IDLE has no effect.
  - abort and start together in IDLE: start wins.
- Async rst mid-job: immediate return to reset values; no pulses.
- Outputs are registered: state, pulses and done all change on the clock edge after the causing input.

Optional Feature:
SEQ_WATCHDOG_EN.
- Defined:
  - A wait counter clears on every state change.
  - It counts cycles in READ, COMP or WRITE after the launch pulse (cycles stalled by rempty/wfull are not counted).
  - When it reaches TIMEOUT: enter ERR and set error=1.
  - ERR is left only by abort (-> IDLE, aborted pulse, error held) or by start (clears error, begins a new job).
- Not defined: no counter, ERR unreachable, error tied 0. Port list is unchanged.

Decomposition:
- Shared package tpu_ctrl_pkg: state encoding constants, DRAIN_CYC function of ARRAY_SIZE, default TIMEOUT.
- One natural sub-module, seq_phase_timer: loadable down-counter serving both the DRAIN count and the watchdog count.

Test Plan:
- ARRAY_SIZE=8, num_tiles=3, each done 5 cycles after its launch -> 3 pulses each of read/compute/write_start; tile_idx 0,1,2; DRAIN exactly 14 cycles per tile; done pulses once.
- num_tiles=0, start -> no *_start pulses; done pulses 2 cycles after start; busy high for 1 cycle.
- Enter READ with rempty=1 for 10 cycles -> read_start is first seen the cycle after rempty falls. Enter WRITE with wfull=1 -> write_start likewise deferred.
- abort during tile 1 DRAIN -> IDLE next cycle, aborted pulse, no done, tile_idx=1. Restart with num_tiles=2 -> job completes normally.
- Spurious compute_done during READ, and read_done on the read_start cycle -> both ignored; state stays READ.
- SEQ_WATCHDOG_EN, TIMEOUT=16, withhold write_done -> ERR after 16 cycles, error=1. Then start -> error=0, new job runs.
